graph_state_ctrl: RTL and testbench

- Owns the point-coordinate and tour-order tables that the 256x256 graph renderer draws.
- Arbitrates writes between two requesters:
  - a point loader, which writes one coordinate pair per request;
  - a tour solver, which issues 2-opt segment reversals executed over multiple cycles.
- All edits go to a shadow copy. The shadow is committed atomically to the display copy after a vblank pulse, so the renderer never sees a half-applied reversal.

---
 rtl/graph_state_ctrl.sv | 163 ++++++++++++++++
 tb/tb_graph_state_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_state_ctrl.sv
// graph_state_ctrl
//   Owns the point-coordinate and tour-order tables drawn by the 256x256
//   graph renderer. A point loader writes one (x,y) pair per request; a tour
//   solver requests 2-opt segment reversals that run over several cycles.
//   Every edit lands in a shadow copy. The shadow is copied to the display
//   copy in one edge, in the first idle cycle after a vblank pulse, so the
//   renderer never sees a half-applied reversal.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   vblank              one-cycle frame-boundary pulse (requests a commit)
//   load_*              loader handshake and payload (index, x, y)
//   swap_*              solver handshake and segment bounds i..j
//   swap_done           one-cycle pulse when a reversal (or no-op) completes
//   busy                high while a swap is in progress
//   commit              one-cycle pulse, the cycle after the display update
//   disp_xs/ys/path     packed display tables, entry k at [k*W +: W]
module graph_state_ctrl #(
  parameter  int N  = 64,
  parameter  int CW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [IW-1:0]     load_idx,
  input  logic [CW-1:0]     load_x,
  input  logic [CW-1:0]     load_y,
  input  logic              swap_valid,
  output logic              swap_ready,
  input  logic [IW-1:0]     swap_i,
  input  logic [IW-1:0]     swap_j,
  output logic              swap_done,
  output logic              busy,
  output logic              commit,
  output logic [N*CW-1:0]   disp_xs,
  output logic [N*CW-1:0]   disp_ys,
  output logic [N*IW-1:0]   disp_path
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_pend;
  logic [IW-1:0] r_lo;
  logic [IW-1:0] r_hi;
  logic          r_swap_done;
  logic          r_commit;

  // Shadow (edited) and display (committed) tables. These stay in flops:
  // the commit copies every entry in a single edge.
  logic [CW-1:0] r_sh_x    [N];
  logic [CW-1:0] r_sh_y    [N];
  logic [IW-1:0] r_sh_path [N];
  logic [CW-1:0] r_dp_x    [N];
  logic [CW-1:0] r_dp_y    [N];
  logic [IW-1:0] r_dp_path [N];

  logic w_load_acc;
  logic w_swap_acc;

  // Loader has fixed priority: a swap request stalls while load_valid is up.
  assign load_ready = (r_state == S_IDLE) && !r_pend;
  assign swap_ready = load_ready && !load_valid;
  assign w_load_acc = load_valid && load_ready;
  assign w_swap_acc = swap_valid && swap_ready;

  assign swap_done = r_swap_done;
  assign commit    = r_commit;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pend      <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_swap_done <= 1'b0;
      r_commit    <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_sh_x[k]    <= '0;
        r_sh_y[k]    <= '0;
        r_sh_path[k] <= IW'(k);
        r_dp_x[k]    <= '0;
        r_dp_y[k]    <= '0;
        r_dp_path[k] <= IW'(k);
      end
    end else begin
      r_swap_done <= 1'b0;
      r_commit    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            for (int k = 0; k < N; k++) begin
              r_dp_x[k]    <= r_sh_x[k];
              r_dp_y[k]    <= r_sh_y[k];
              r_dp_path[k] <= r_sh_path[k];
            end
            r_commit <= 1'b1;
          end else if (w_load_acc) begin
            r_sh_x[load_idx] <= load_x;
            r_sh_y[load_idx] <= load_y;
          end else if (w_swap_acc) begin
            r_lo <= swap_i;
            r_hi <= swap_j;
            if (swap_i < swap_j) begin
              r_state <= S_REV;
            end else begin
              // Empty or inverted segment: nothing to reverse.
              r_state     <= S_DONE;
              r_swap_done <= 1'b1;
            end
          end
        end

        S_REV: begin
          r_sh_path[r_lo] <= r_sh_path[r_hi];
          r_sh_path[r_hi] <= r_sh_path[r_lo];
          r_lo <= r_lo + IW'(1);
          r_hi <= r_hi - IW'(1);
          // lo < hi always holds here, so the difference never wraps.
          // A gap of 1 or 2 means this is the last swap of the segment.
          if ((r_hi - r_lo) <= IW'(2)) begin
            r_state     <= S_DONE;
            r_swap_done <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // A new vblank wins over the clear of the commit it would otherwise
      // be racing; a vblank while already pending just merges.
      if (vblank) begin
        r_pend <= 1'b1;
      end else if ((r_state == S_IDLE) && r_pend) begin
        r_pend <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign disp_xs[gi*CW +: CW]   = r_dp_x[gi];
      assign disp_ys[gi*CW +: CW]   = r_dp_y[gi];
      assign disp_path[gi*IW +: IW] = r_dp_path[gi];
    end
  endgenerate

endmodule

// File: tb/tb_graph_state_ctrl.sv
`timescale 1ns/1ps
module tb_graph_state_ctrl;
  localparam int N  = 64;
  localparam int CW = 8;
  localparam int IW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            vblank;
  logic            load_valid;
  logic            load_ready;
  logic [IW-1:0]   load_idx;
  logic [CW-1:0]   load_x;
  logic [CW-1:0]   load_y;
  logic            swap_valid;
  logic            swap_ready;
  logic [IW-1:0]   swap_i;
  logic [IW-1:0]   swap_j;
  logic            swap_done;
  logic            busy;
  logic            commit;
  logic [N*CW-1:0] disp_xs;
  logic [N*CW-1:0] disp_ys;
  logic [N*IW-1:0] disp_path;

  graph_state_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .vblank(vblank),
    .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y),
    .swap_valid(swap_valid), .swap_ready(swap_ready), .swap_i(swap_i), .swap_j(swap_j),
    .swap_done(swap_done), .busy(busy), .commit(commit),
    .disp_xs(disp_xs), .disp_ys(disp_ys), .disp_path(disp_path)
  );

  // Scoreboard entry: kind 0 = swap_done expected (cyc = busy cycles),
  // kind 1 = commit expected (snapshot of the shadow model).
  typedef struct {
    int              kind;
    int              cyc;
    logic [N*CW-1:0] xs;
    logic [N*CW-1:0] ys;
    logic [N*IW-1:0] path;
  } exp_t;

  exp_t sb[$];
  exp_t mon_it;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: shadow tables as plain arrays, display as packed copies.
  int              m_x    [N];
  int              m_y    [N];
  int              m_path [N];
  logic [N*CW-1:0] m_dxs;
  logic [N*CW-1:0] m_dys;
  logic [N*IW-1:0] m_dpath;
  bit              m_pend;
  int              busy_cnt = 0;

  task automatic chk_int(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic chk_vec(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    $display("FAIL %s: event seen/missed, required the opposite", name);
  endtask

  function automatic logic [N*CW-1:0] pack_xy(input int a[N]);
    logic [N*CW-1:0] r;
    for (int k = 0; k < N; k++) r[k*CW +: CW] = CW'(a[k]);
    return r;
  endfunction

  function automatic logic [N*IW-1:0] pack_path(input int a[N]);
    logic [N*IW-1:0] r;
    for (int k = 0; k < N; k++) r[k*IW +: IW] = IW'(a[k]);
    return r;
  endfunction

  function automatic logic [N*IW-1:0] ident_path();
    logic [N*IW-1:0] r;
    for (int k = 0; k < N; k++) r[k*IW +: IW] = IW'(k);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_path[k] = k;
    end
    m_dxs   = '0;
    m_dys   = '0;
    m_dpath = ident_path();
    m_pend  = 1'b0;
    sb.delete();
  endtask

  // Monitor: pops expectations when the DUT presents swap_done / commit and
  // checks the display tables every cycle against the committed model.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (swap_done) begin
        if (sb.size() > 0 && sb[0].kind == 0) begin
          mon_it = sb.pop_front();
          chk_int("swap_busy_cycles", busy_cnt, mon_it.cyc);
        end else begin
          fail_evt("unexpected_swap_done");
        end
        busy_cnt = 0;
      end
      if (commit) begin
        if (sb.size() > 0 && sb[0].kind == 1) begin
          mon_it = sb.pop_front();
          chk_vec("commit_xs", 512'(disp_xs), 512'(mon_it.xs));
          chk_vec("commit_ys", 512'(disp_ys), 512'(mon_it.ys));
          chk_vec("commit_path", 512'(disp_path), 512'(mon_it.path));
          m_dxs   = mon_it.xs;
          m_dys   = mon_it.ys;
          m_dpath = mon_it.path;
          m_pend  = 1'b0;
        end else begin
          fail_evt("unexpected_commit");
        end
      end
      chk_vec("disp_xs_stable", 512'(disp_xs), 512'(m_dxs));
      chk_vec("disp_ys_stable", 512'(disp_ys), 512'(m_dys));
      chk_vec("disp_path_stable", 512'(disp_path), 512'(m_dpath));
    end
  end

  // All stimulus tasks start and end 1 ns after a rising edge.
  task automatic do_load(input int idx, input int x, input int y);
    int n = 0;
    load_idx = IW'(idx); load_x = CW'(x); load_y = CW'(y); load_valid = 1'b1;
    @(negedge clk);
    while (!load_ready && n < 300) begin n++; @(negedge clk); end
    if (!load_ready) fail_evt("load_accept_timeout");
    @(posedge clk); #1;
    load_valid = 1'b0;
    m_x[idx] = x; m_y[idx] = y;
  endtask

  task automatic do_swap(input int i, input int j);
    int n = 0;
    int tmp[N];
    exp_t e;
    swap_i = IW'(i); swap_j = IW'(j); swap_valid = 1'b1;
    @(negedge clk);
    while (!swap_ready && n < 300) begin n++; @(negedge clk); end
    if (!swap_ready) fail_evt("swap_accept_timeout");
    @(posedge clk); #1;
    swap_valid = 1'b0;
    // Whole-segment reversal: new[i+k] = old[j-k].
    if (i < j) begin
      tmp = m_path;
      for (int k = 0; k <= j - i; k++) m_path[i+k] = tmp[j-k];
    end
    e.kind = 0;
    e.cyc  = (i < j) ? ((j - i + 1) / 2 + 1) : 1;
    e.xs = '0; e.ys = '0; e.path = '0;
    sb.push_back(e);
  endtask

  task automatic pulse_vblank();
    exp_t e;
    if (!m_pend) begin
      m_pend = 1'b1;
      e.kind = 1; e.cyc = 0;
      e.xs = pack_xy(m_x); e.ys = pack_xy(m_y); e.path = pack_path(m_path);
      sb.push_back(e);
    end
    vblank = 1'b1;
    @(posedge clk); #1;
    vblank = 1'b0;
  endtask

  // Only used while idle with nothing pending: commit must show 2 cycles on.
  task automatic vblank_commit_timed();
    int n = 0;
    pulse_vblank();
    do begin @(negedge clk); n++; end while (!commit && n < 10);
    chk_int("commit_delay", n, 2);
    @(posedge clk); #1;
  endtask

  task automatic wait_quiet();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 500) begin n++; @(negedge clk); end
    if (n >= 500) fail_evt("wait_quiet_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp7[7];
    int n, sd_at, cm_at;
    exp7[0] = 0; exp7[1] = 1; exp7[2] = 5; exp7[3] = 4;
    exp7[4] = 3; exp7[5] = 2; exp7[6] = 6;

    rst = 1'b1; vblank = 1'b0; load_valid = 1'b0; swap_valid = 1'b0;
    load_idx = '0; load_x = '0; load_y = '0; swap_i = '0; swap_j = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk_vec("reset_path", 512'(disp_path), 512'(ident_path()));
    chk_vec("reset_xs", 512'(disp_xs), 512'(0));
    chk_vec("reset_ys", 512'(disp_ys), 512'(0));
    chk_int("reset_load_ready", int'(load_ready), 1);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_commit", int'(commit), 0);
    @(posedge clk); #1;

    // Load and commit
    do_load(3, 8'h40, 8'h80);
    @(negedge clk);
    chk_int("disp_x3_before_vblank", int'(disp_xs[3*CW +: CW]), 0);
    @(posedge clk); #1;
    vblank_commit_timed();
    chk_int("disp_x3_after_commit", int'(disp_xs[3*CW +: CW]), 8'h40);
    chk_int("disp_y3_after_commit", int'(disp_ys[3*CW +: CW]), 8'h80);

    // Reversals
    do_swap(2, 5);
    wait_quiet();
    vblank_commit_timed();
    for (int k = 0; k < 7; k++)
      chk_int($sformatf("path_2_5_entry%0d", k), int'(disp_path[k*IW +: IW]), exp7[k]);
    do_swap(0, 63);
    wait_quiet();
    vblank_commit_timed();
    chk_int("full_rev_path0", int'(disp_path[0 +: IW]), 63);
    chk_int("full_rev_path63", int'(disp_path[63*IW +: IW]), 0);

    // Arbitration: load wins, swap goes next cycle
    load_idx = 6'd12; load_x = 8'h11; load_y = 8'h22; load_valid = 1'b1;
    swap_i = 6'd1; swap_j = 6'd4; swap_valid = 1'b1;
    @(negedge clk);
    chk_int("arb_load_ready", int'(load_ready), 1);
    chk_int("arb_swap_ready_blocked", int'(swap_ready), 0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    m_x[12] = 8'h11; m_y[12] = 8'h22;
    swap_valid = 1'b0;
    do_swap(1, 4);
    wait_quiet();

    // No-op swaps
    do_swap(7, 7);
    do_swap(9, 4);
    wait_quiet();
    vblank_commit_timed();

    // vblank mid-reversal, second vblank absorbed
    do_swap(10, 20);
    pulse_vblank();
    pulse_vblank();
    n = 0; sd_at = -1; cm_at = -1;
    while (cm_at < 0 && n < 100) begin
      @(negedge clk); n++;
      if (swap_done) sd_at = n;
      if (commit) cm_at = n;
      else chk_int("ready_low_while_pending", int'(load_ready), 0);
    end
    chk_int("commit_after_done_gap", cm_at - sd_at, 2);
    @(posedge clk); #1;
    wait_quiet();

    // Reset mid-operation with a commit pending
    do_swap(0, 63);
    pulse_vblank();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk_int("midrst_busy", int'(busy), 0);
    chk_int("midrst_load_ready", int'(load_ready), 1);
    chk_vec("midrst_path", 512'(disp_path), 512'(ident_path()));
    @(posedge clk); #1;

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        do_load(int'($urandom_range(0, N-1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
      end else if (r <= 6) begin
        do_swap(int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)));
      end else if (r <= 8) begin
        if (!m_pend) pulse_vblank();
      end else begin
        repeat (int'($urandom_range(0, 3))) @(posedge clk);
        #1;
      end
    end
    if (!m_pend) pulse_vblank();
    wait_quiet();
    chk_int("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
